// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: round-robin arbiter sharing an async-read ROM between two burst requesters
//  clk, rst_n               clock, asynchronous active-low reset
//  req0/addr0/len0 -> gnt0  requester 0: burst request, start address, beats-1, grant pulse
//  req1/addr1/len1 -> gnt1  requester 1: same as requester 0
//  rom_addr -> rom_data     registered ROM address, combinational ROM read data
//  rd_data/rd_valid/rd_last/rd_owner  registered read beat with valid, final-beat and owner tags
//  busy                     high while a burst is in progress
module rom_burst_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] len0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] len1,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              rd_owner,
  output logic              busy
);
  localparam logic IDLE  = 1'b0;
  localparam logic BURST = 1'b1;
  logic              state;
  logic              owner;
  logic              last_owner;
  logic              win;
  logic [ADDR_W-1:0] cnt;
  // on a tie the requester that was not served last wins; otherwise the sole requester
  assign win  = (req0 && req1) ? ~last_owner : ~req0;
  assign busy = state == BURST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      rom_addr   <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_owner   <= 1'b0;
    end else if (state == IDLE) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (req0 || req1) begin
        gnt0       <= ~win;
        gnt1       <= win;
        rom_addr   <= win ? addr1 : addr0;
        cnt        <= win ? len1 : len0;
        owner      <= win;
        last_owner <= win;
        state      <= BURST;
      end
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rd_data  <= rom_data;
      rd_valid <= 1'b1;
      rd_owner <= owner;
      rd_last  <= cnt == '0;
      if (cnt == '0) begin
        state <= IDLE;
      end else begin
        rom_addr <= rom_addr + 1'b1;
        cnt      <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb_rom_burst_arbiter: randomized and directed bench for rom_burst_arbiter with a burst-level reference model
module tb_rom_burst_arbiter;
  typedef struct {logic [5:0] a; logic [5:0] l;} rq_t;
  typedef struct {logic [7:0] d; logic last; logic own; int cyc;} beat_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [5:0] addr0 = '0, addr1 = '0, len0 = '0, len1 = '0;
  logic       gnt0, gnt1, rd_valid, rd_last, rd_owner, busy;
  logic [5:0] rom_addr;
  logic [7:0] rom_data, rd_data;
  logic [7:0] rom_mem [64];
  rq_t        q0[$], q1[$], m0[$], m1[$];
  beat_t      obs[$], expb[$];
  int         gq[$], eg[$];
  int         cyc = 0, busy_cnt = 0, exp_busy = 0, lo = 1;
  int         checks = 0, failures = 0;
  bit         stray = 1'b0;
  always #5 clk = ~clk;
  assign rom_data = rom_mem[rom_addr];
  rom_burst_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_owner(rd_owner),
    .busy(busy)
  );
  // requesters: present the head of their queue, retire it when granted
  always @(negedge clk) begin
    if (gnt0 && q0.size() > 0) void'(q0.pop_front());
    if (gnt1 && q1.size() > 0) void'(q1.pop_front());
    if (q0.size() > 0) begin req0 = 1'b1; addr0 = q0[0].a; len0 = q0[0].l; end else req0 = 1'b0;
    if (q1.size() > 0) begin req1 = 1'b1; addr1 = q1[0].a; len1 = q1[0].l; end else req1 = 1'b0;
  end
  // monitor: record beats, grants and busy cycles
  always @(negedge clk) begin
    cyc++;
    if (rd_valid) obs.push_back('{rd_data, rd_last, rd_owner, cyc});
    if (rd_last && !rd_valid) stray = 1'b1;
    if (gnt0 && gnt1) stray = 1'b1;
    if (gnt0) gq.push_back(0);
    if (gnt1) gq.push_back(1);
    if (busy) busy_cnt++;
  end
  task automatic clr();
    obs.delete(); gq.delete(); expb.delete(); eg.delete();
    busy_cnt = 0; exp_busy = 0;
  endtask
  task automatic push(input int r, input logic [5:0] a, input logic [5:0] l);
    if (r == 1) begin q1.push_back('{a, l}); m1.push_back('{a, l}); end
    else begin q0.push_back('{a, l}); m0.push_back('{a, l}); end
  endtask
  // reference: serve queued bursts round-robin, each as len+1 consecutive ROM bytes
  task automatic model();
    rq_t r;
    int  w;
    while (m0.size() > 0 || m1.size() > 0) begin
      w = (m0.size() > 0 && m1.size() > 0) ? 1 - lo : (m0.size() > 0 ? 0 : 1);
      r = (w == 1) ? m1.pop_front() : m0.pop_front();
      eg.push_back(w);
      for (int i = 0; i <= int'(r.l); i++)
        expb.push_back('{rom_mem[(int'(r.a) + i) % 64], i == int'(r.l), w[0], 0});
      exp_busy += int'(r.l) + 1;
      lo = w;
    end
  endtask
  task automatic run(output bit to);
    int n = 0;
    int budget = 2 * expb.size() + 40;
    while (obs.size() < expb.size() && n < budget) begin @(negedge clk); n++; end
    to = n >= budget;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({gnt0, gnt1, rd_valid, rd_last, rd_owner, busy, rom_addr, rd_data} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {gnt0, gnt1, rd_valid, rd_last, rd_owner, busy, rom_addr, rd_data});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, rd_valid, rd_last, busy} !== 5'h0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=00000", {gnt0, gnt1, rd_valid, rd_last, busy});
    end
  endtask
  task automatic test_bursts(input bit rnd, input int nb);
    bit to;
    int k;
    for (int b = 0; b < nb; b++) begin
      @(posedge clk); #1;
      clr();
      if (rnd) begin
        foreach (rom_mem[i]) rom_mem[i] = 8'($urandom);
        k = 0;
        for (int r = 0; r < 2; r++)
          if ($urandom_range(0, 2) != 0 || (r == 1 && k == 0))
            for (int j = $urandom_range(1, 3); j > 0; j--) begin
              push(r, 6'($urandom), $urandom_range(0, 5) == 0 ? 6'($urandom) : 6'($urandom_range(0, 6)));
              k++;
            end
      end else if (b == 0) begin
        push(0, 6'd40, 6'd1); push(0, 6'd44, 6'd1); push(1, 6'd50, 6'd1); push(1, 6'd54, 6'd1);
      end else if (b == 1) push(0, 6'd5, 6'd3);
      else if (b == 2) push(1, 6'd62, 6'd3);
      else if (b == 3) push(0, 6'd20, 6'd0);
      else push(0, 6'd0, 6'd63);
      model();
      run(to);
      checks++;
      if (to || obs.size() != expb.size()) begin
        failures++;
        $display("FAIL beat_count batch=%0d got=%0d want=%0d timeout=%0d", b, obs.size(), expb.size(), to);
      end
      for (int i = 0; i < obs.size() && i < expb.size(); i++) begin
        checks++;
        if (obs[i].d !== expb[i].d || obs[i].last !== expb[i].last || obs[i].own !== expb[i].own) begin
          failures++;
          $display("FAIL beat batch=%0d idx=%0d got=%h/last%b/own%b want=%h/last%b/own%b", b, i,
                   obs[i].d, obs[i].last, obs[i].own, expb[i].d, expb[i].last, expb[i].own);
        end
        if (i > 0) begin
          checks++;
          if (obs[i].cyc - obs[i-1].cyc != (expb[i-1].last ? 2 : 1)) begin
            failures++;
            $display("FAIL beat_gap batch=%0d idx=%0d got=%0d want=%0d", b, i, obs[i].cyc - obs[i-1].cyc, expb[i-1].last ? 2 : 1);
          end
        end
      end
      checks++;
      if (gq != eg) begin
        failures++;
        $display("FAIL grant_order batch=%0d got=%p want=%p", b, gq, eg);
      end
      checks++;
      if (busy_cnt != exp_busy) begin
        failures++;
        $display("FAIL busy_cycles batch=%0d got=%0d want=%0d", b, busy_cnt, exp_busy);
      end
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL stray_flags got=1 want=0");
    end
  endtask
  task automatic test_reset_mid();
    bit to;
    int n = 0;
    foreach (rom_mem[i]) rom_mem[i] = 8'(i);
    @(posedge clk); #1;
    clr();
    push(0, 6'd0, 6'd7);
    m0.delete();
    while (obs.size() < 2 && n < 40) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= 40 || !rd_valid) begin
      failures++;
      $display("FAIL mid_burst_reach got=%0d beats want=2", obs.size());
    end
    rst_n = 1'b0;
    q0.delete(); q1.delete(); m0.delete(); m1.delete();
    lo = 1;
    #1;
    checks++;
    if ({gnt0, gnt1, rd_valid, rd_last, rd_owner, busy, rom_addr, rd_data} !== 20'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h want=0", {gnt0, gnt1, rd_valid, rd_last, rd_owner, busy, rom_addr, rd_data});
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    clr();
    repeat (6) @(negedge clk);
    checks++;
    if (obs.size() != 0 || busy_cnt != 0) begin
      failures++;
      $display("FAIL burst_resumed got=%0d beats want=0", obs.size());
    end
    @(posedge clk); #1;
    clr();
    push(1, 6'd9, 6'd0);
    model();
    run(to);
    checks++;
    if (to || obs.size() != 1 || obs[0].d !== 8'h09 || obs[0].last !== 1'b1 || obs[0].own !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_beat got=%0d beats first=%h want=1 beat 09 last=1 own=1", obs.size(), obs.size() > 0 ? obs[0].d : 8'hxx);
    end
  endtask
  initial begin
    foreach (rom_mem[i]) rom_mem[i] = 8'(i);
    test_reset();
    test_bursts(1'b0, 5);
    test_bursts(1'b1, 25);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
